// File: rtl/sparc_exu_defs.sv
// Shared defaults for the EXU per-thread state registers: thread count, widths,
// reset constant, and a one-hot check helper.
package sparc_exu_defs;

  localparam int          DEF_NTHR      = 4;
  localparam int          DEF_SIZE      = 3;
  localparam int          MAX_NTHR      = 8;
  localparam logic [63:0] DEF_RESET_VAL = 64'd0;

  // True when more than one bit of a (zero-padded) thread vector is set.
  function automatic logic multi_hot(input logic [MAX_NTHR-1:0] vec);
    return ((vec & (vec - 8'd1)) != 8'd0);
  endfunction

endpackage

// File: rtl/sparc_exu_thrreg_ent.sv
// One per-thread entry: loads commit data when enabled, synchronous reset to
// RESET_VAL.
module sparc_exu_thrreg_ent #(
  parameter int             SIZE      = 3,
  parameter logic [SIZE-1:0] RESET_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            commit,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_r;

  // Entry flop with commit-enable mux.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      q_r <= RESET_VAL;
    end else if (commit) begin
      q_r <= din;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sparc_exu_thrreg.sv
// Per-thread architectural state register with a one-deep write stage that a
// W+1 kill can cancel. Optional read bypass: define SPARC_EXU_THRREG_BYPASS_EN.
module sparc_exu_thrreg
  import sparc_exu_defs::*;
#(
  parameter int              SIZE      = DEF_SIZE,
  parameter int              NTHR      = DEF_NTHR,
  parameter logic [SIZE-1:0] RESET_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NTHR-1:0] thr_out,
  input  logic            wen_w,
  input  logic [NTHR-1:0] thr_w,
  input  logic [SIZE-1:0] data_in_w,
  input  logic            kill_w1,
  output logic [SIZE-1:0] data_out,
  output logic            wr_pend,
  output logic            err_sel
);

  logic            pend_vld_r;
  logic [NTHR-1:0] pend_thr_r;
  logic [SIZE-1:0] pend_data_r;
  logic            err_sel_r;

  logic [NTHR-1:0]     commit_s;
  logic [SIZE-1:0]     entry_s [NTHR];
  logic [SIZE-1:0]     data_out_s;
  logic [MAX_NTHR-1:0] sel_pad_s;

  // Write stage; a new write always loads, kill only affects the old contents.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pend_vld_r  <= 1'b0;
      pend_thr_r  <= {NTHR{1'b0}};
      pend_data_r <= {SIZE{1'b0}};
    end else begin
      pend_vld_r  <= wen_w & (|thr_w);
      pend_thr_r  <= thr_w;
      pend_data_r <= data_in_w;
    end
  end

  assign commit_s = {NTHR{pend_vld_r & ~kill_w1}} & pend_thr_r;

  genvar gi;
  generate
    for (gi = 0; gi < NTHR; gi++) begin : g_ent
      sparc_exu_thrreg_ent #(
        .SIZE      (SIZE),
        .RESET_VAL (RESET_VAL)
      ) u_ent (
        .clk    (clk),
        .rst_l  (rst_l),
        .commit (commit_s[gi]),
        .din    (pend_data_r),
        .q      (entry_s[gi])
      );
    end
  endgenerate

  // Read OR-mux over the selected threads.
  always_comb begin
    data_out_s = {SIZE{1'b0}};
    for (int i = 0; i < NTHR; i++) begin
      if (thr_out[i]) begin
`ifdef SPARC_EXU_THRREG_BYPASS_EN
        if (commit_s[i]) begin
          data_out_s = data_out_s | pend_data_r;
        end else begin
          data_out_s = data_out_s | entry_s[i];
        end
`else
        data_out_s = data_out_s | entry_s[i];
`endif
      end else begin
        data_out_s = data_out_s;
      end
    end
  end

  // Zero-pad the read select so the shared helper can check it.
  always_comb begin
    sel_pad_s = {MAX_NTHR{1'b0}};
    sel_pad_s[NTHR-1:0] = thr_out;
  end

  // Sticky multi-hot read select flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      err_sel_r <= 1'b0;
    end else if (multi_hot(sel_pad_s)) begin
      err_sel_r <= 1'b1;
    end else begin
      err_sel_r <= err_sel_r;
    end
  end

  assign data_out = data_out_s;
  assign wr_pend  = pend_vld_r;
  assign err_sel  = err_sel_r;

endmodule

// File: tb/tb_sparc_exu_thrreg.sv
// Directed self-checking bench for sparc_exu_thrreg (SIZE=3, NTHR=4,
// RESET_VAL=3'b101); expectations follow SPARC_EXU_THRREG_BYPASS_EN.
module tb_sparc_exu_thrreg;

`ifdef SPARC_EXU_THRREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] thr_out;
  logic       wen_w;
  logic [3:0] thr_w;
  logic [2:0] data_in_w;
  logic       kill_w1;
  logic [2:0] data_out;
  logic       wr_pend;
  logic       err_sel;

  int pass_cnt = 0;
  int total_cnt = 0;

  sparc_exu_thrreg #(
    .SIZE      (3),
    .NTHR      (4),
    .RESET_VAL (3'b101)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .thr_out   (thr_out),
    .wen_w     (wen_w),
    .thr_w     (thr_w),
    .data_in_w (data_in_w),
    .kill_w1   (kill_w1),
    .data_out  (data_out),
    .wr_pend   (wr_pend),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [3:0] sel, input logic [2:0] exp);
    thr_out = sel;
    #1;
    check(tag, {29'd0, data_out}, {29'd0, exp});
  endtask

  initial begin
    rst_l = 1'b0; thr_out = 4'b0000; wen_w = 1'b0; thr_w = 4'b0000;
    data_in_w = 3'b000; kill_w1 = 1'b0;
    tick(); tick();
    rst_l = 1'b1;
    #1;
    // Reset state
    rd("rst_t0", 4'b0001, 3'b101);
    rd("rst_t1", 4'b0010, 3'b101);
    rd("rst_t2", 4'b0100, 3'b101);
    rd("rst_t3", 4'b1000, 3'b101);
    rd("rst_none", 4'b0000, 3'b000);
    check("rst_wr_pend", {31'd0, wr_pend}, 32'd0);
    check("rst_err_sel", {31'd0, err_sel}, 32'd0);

    // Basic write to thread 1
    wen_w = 1'b1; thr_w = 4'b0010; data_in_w = 3'b011;
    rd("wr_n", 4'b0010, 3'b101);
    tick();
    wen_w = 1'b0; thr_w = 4'b0000; data_in_w = 3'b000;
    check("wr_pend_n1", {31'd0, wr_pend}, 32'd1);
    rd("wr_n1", 4'b0010, BYP ? 3'b011 : 3'b101);
    tick();
    check("wr_pend_n2", {31'd0, wr_pend}, 32'd0);
    rd("wr_n2", 4'b0010, 3'b011);

    // Kill in N+1 with a new same-thread write in N+1 (thread 2)
    wen_w = 1'b1; thr_w = 4'b0100; data_in_w = 3'b011;
    tick();
    kill_w1 = 1'b1; data_in_w = 3'b110;
    rd("kill_n1", 4'b0100, 3'b101);
    tick();
    kill_w1 = 1'b0; wen_w = 1'b0; thr_w = 4'b0000; data_in_w = 3'b000;
    check("kill_wr_pend", {31'd0, wr_pend}, 32'd1);
    rd("kill_n2", 4'b0100, BYP ? 3'b110 : 3'b101);
    tick();
    rd("kill_n3", 4'b0100, 3'b110);

    // Killed write alone (thread 0) never lands
    wen_w = 1'b1; thr_w = 4'b0001; data_in_w = 3'b011;
    tick();
    wen_w = 1'b0; thr_w = 4'b0000; kill_w1 = 1'b1;
    rd("killonly_n1", 4'b0001, 3'b101);
    tick();
    check("killonly_pend", {31'd0, wr_pend}, 32'd0);
    tick();
    kill_w1 = 1'b0;
    rd("killonly_late", 4'b0001, 3'b101);

    // Broadcast, then wen with empty thread vector
    wen_w = 1'b1; thr_w = 4'b1111; data_in_w = 3'b111;
    tick();
    thr_w = 4'b0000; data_in_w = 3'b000;
    check("bc_pend", {31'd0, wr_pend}, 32'd1);
    tick();
    wen_w = 1'b0;
    check("nop_pend", {31'd0, wr_pend}, 32'd0);
    rd("bc_t0", 4'b0001, 3'b111);
    rd("bc_t1", 4'b0010, 3'b111);
    rd("bc_t2", 4'b0100, 3'b111);
    rd("bc_t3", 4'b1000, 3'b111);
    tick();
    rd("nop_t3", 4'b1000, 3'b111);

    // Back-to-back same-thread writes (thread 0)
    wen_w = 1'b1; thr_w = 4'b0001; data_in_w = 3'b001;
    tick();
    data_in_w = 3'b010;
    tick();
    wen_w = 1'b0; thr_w = 4'b0000; data_in_w = 3'b000;
    rd("b2b_n2", 4'b0001, BYP ? 3'b010 : 3'b001);
    tick();
    rd("b2b_n3", 4'b0001, 3'b010);

    // Multi-hot read: thread 0 = 001, thread 2 = 100
    wen_w = 1'b1; thr_w = 4'b0001; data_in_w = 3'b001;
    tick();
    thr_w = 4'b0100; data_in_w = 3'b100;
    tick();
    wen_w = 1'b0; thr_w = 4'b0000; data_in_w = 3'b000;
    tick(); tick();
    check("err_pre", {31'd0, err_sel}, 32'd0);
    rd("multi_or", 4'b0101, 3'b101);
    check("err_same_cyc", {31'd0, err_sel}, 32'd0);
    tick();
    check("err_set", {31'd0, err_sel}, 32'd1);
    thr_out = 4'b0001;
    tick(); tick();
    check("err_held", {31'd0, err_sel}, 32'd1);

    // Reset after a write; also a same-cycle write under reset
    wen_w = 1'b1; thr_w = 4'b0010; data_in_w = 3'b000;
    tick();
    rst_l = 1'b0; thr_w = 4'b1000; data_in_w = 3'b000;
    tick();
    rst_l = 1'b1; wen_w = 1'b0; thr_w = 4'b0000;
    rd("rst2_t1", 4'b0010, 3'b101);
    rd("rst2_t0", 4'b0001, 3'b101);
    check("rst2_pend", {31'd0, wr_pend}, 32'd0);
    check("rst2_err", {31'd0, err_sel}, 32'd0);
    tick();
    rd("rst2_t3", 4'b1000, 3'b101);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
